ram_bus_arbiter: RTL

Two-requester arbiter that shares the single RAM port (cs/we/oe, 64-bit address, 64-bit data) between the CPU (master 0) and a DMA/debug engine (master 1). Each master issues single-beat read or write transactions with a req/ack handshake. The arbiter owns all RAM strobes and sequences each access over a fixed RAM latency. It sits between the cpu top, the second master and the ram model; the top level ties ram_wdata/ram_wdata_oe onto the tristate data bus.

---
 rtl/ram_bus_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_bus_arbiter.sv
// Two-master single-beat arbiter in front of a fixed-latency RAM port.
// Build option: define RAM_ARB_FIXED_PRIO_EN to give m0 absolute priority.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   mN_req/we/addr/wdata  master N request bundle, held until mN_ack
//   mN_ack/rdata          one-cycle completion pulse, read data
//   gnt, busy             one-hot current owner, transaction in flight
//   ram_cs/we/oe/addr     RAM strobes and address
//   ram_wdata/wdata_oe    write data and bus drive enable
//   ram_rdata             RAM read data
module ram_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             pick_valid;
  logic             pick;
  logic             sel_we;

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Index of the master served last; the other one wins a tie.
  logic last_gnt;
`endif

  always_comb begin
    pick_valid = m0_req | m1_req;
    pick       = 1'b0;
    if (m0_req && m1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = ~last_gnt;
`endif
    end else begin
      pick = m1_req;
    end
    sel_we = pick ? m1_we : m0_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      gnt          <= 2'b00;
      busy         <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_oe       <= 1'b0;
      ram_wdata_oe <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state        <= S_ACCESS;
            gnt          <= pick ? 2'b10 : 2'b01;
            busy         <= 1'b1;
            lat_we       <= sel_we;
            cnt          <= CNT_W'(RAM_LAT - 1);
            ram_addr     <= pick ? m1_addr : m0_addr;
            ram_wdata    <= pick ? m1_wdata : m0_wdata;
            ram_cs       <= 1'b1;
            ram_we       <= sel_we;
            ram_oe       <= ~sel_we;
            ram_wdata_oe <= sel_we;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (gnt[1]) m1_rdata <= ram_rdata;
              else        m0_rdata <= ram_rdata;
            end
            m0_ack       <= gnt[0];
            m1_ack       <= gnt[1];
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata_oe <= 1'b0;
            state        <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          gnt       <= 2'b00;
          busy      <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_gnt  <= gnt[1];
`endif
        end
        default: begin
          state        <= S_IDLE;
          gnt          <= 2'b00;
          busy         <= 1'b0;
          ram_cs       <= 1'b0;
          ram_we       <= 1'b0;
          ram_oe       <= 1'b0;
          ram_wdata_oe <= 1'b0;
          ram_addr     <= '0;
          ram_wdata    <= '0;
        end
      endcase
    end
  end

endmodule
